// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and constants for the SHA-256 message sequencer
package sha256_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 512;
  localparam int DIGEST_W        = 256;
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_ABORT
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PROTO   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/sha256_block_buf.sv
// rtl/sha256_block_buf.sv - 16x32 word-to-block assembler; word 0 lands in block[511:480]
module sha256_block_buf
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [WORD_W-1:0]  wr_data,
  output logic [IDX_W-1:0]   idx,
  output logic [BLOCK_W-1:0] block
);

  logic [WORD_W-1:0] words [WORDS_PER_BLOCK];

  // The index wraps 15 -> 0 on its own, so a completed block leaves it ready for the next one.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx <= '0;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) words[i] <= '0;
    end else if (wr_en) begin
      words[idx] <= wr_data;
      idx        <= idx + IDX_W'(1);
    end
  end

  always_comb begin
    block = '0;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) block[BLOCK_W-1-WORD_W*i -: WORD_W] = words[i];
  end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// rtl/sha256_msg_sequencer.sv - feeds 512-bit blocks to the SHA-256 core, guards it, holds the digest
module sha256_msg_sequencer
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic                iClk,
  input  logic                iReset,
  input  logic                iWordValid,
  input  logic [WORD_W-1:0]   iWord,
  input  logic                iWordLast,
  output logic                oWordReady,
  input  logic                iAbort,
  output logic [DIGEST_W-1:0] oHash,
  output logic                oHashValid,
  input  logic                iHashAck,
  output logic                oBusy,
  output logic [1:0]          oError,
  output logic [CNT_W-1:0]    oBlockCount,
  output logic                oCoreStart,
  output logic [BLOCK_W-1:0]  oCoreBlock,
  output logic                oCoreBlockValid,
  output logic                oCoreSoftRst,
  input  logic                iCoreBusy,
  input  logic                iCoreDone,
  input  logic [DIGEST_W-1:0] iCoreHash
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state, state_next;
  logic [WD_W-1:0]     wd;
  logic                first_blk, last_blk;
  logic [1:0]          error;
  logic [DIGEST_W-1:0] hash;
  logic                hash_valid;
  logic [CNT_W-1:0]    blk_cnt;
  logic [IDX_W-1:0]    word_idx;
  logic [BLOCK_W-1:0]  block;
  logic                accept, slot_full, proto_err, timeout, buf_clear;

  sha256_block_buf u_buf (
    .clk     (iClk),
    .reset   (iReset),
    .clear   (buf_clear),
    .wr_en   (accept),
    .wr_data (iWord),
    .idx     (word_idx),
    .block   (block)
  );

  // An abort in FILL drops ready so the word on the bus that cycle is not taken.
  assign oWordReady = (state == ST_IDLE) || ((state == ST_FILL) && !iAbort);
  assign accept     = iWordValid && oWordReady;
  assign slot_full  = (word_idx == IDX_W'(WORDS_PER_BLOCK - 1));
  assign proto_err  = accept && iWordLast && !slot_full;
  assign buf_clear  = proto_err || (state == ST_ABORT);
  // The edge that would carry the watchdog to TIMEOUT_CYCLES-1 is the timeout edge.
  assign timeout    = (state == ST_WAIT) && (wd == WD_W'(TIMEOUT_CYCLES - 2));

  always_comb begin
    state_next      = state;
    oCoreBlockValid = 1'b0;
    oCoreStart      = 1'b0;
    oCoreSoftRst    = 1'b0;
    case (state)
      ST_IDLE:  if (accept && !proto_err) state_next = ST_FILL;
      ST_FILL: begin
        if (iAbort)                      state_next = ST_ABORT;
        else if (proto_err)              state_next = ST_IDLE;
        else if (accept && slot_full)    state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        oCoreBlockValid = 1'b1;
        oCoreStart      = first_blk;
        state_next      = iAbort ? ST_ABORT : ST_WAIT;
      end
      ST_WAIT: begin
        if (iAbort || timeout)           state_next = ST_ABORT;
        else if (iCoreDone)              state_next = last_blk ? ST_HOLD : ST_FILL;
      end
      ST_HOLD:  if (iHashAck) state_next = ST_IDLE;
      ST_ABORT: begin
        oCoreSoftRst = 1'b1;
        state_next   = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state      <= ST_IDLE;
      wd         <= '0;
      first_blk  <= 1'b1;
      last_blk   <= 1'b0;
      error      <= ERR_NONE;
      hash       <= '0;
      hash_valid <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: if (accept) error <= proto_err ? ERR_PROTO : ERR_NONE;
        ST_FILL: begin
          if (proto_err) begin
            error     <= ERR_PROTO;
            first_blk <= 1'b1;
            blk_cnt   <= '0;
          end else if (accept && slot_full) begin
            last_blk <= iWordLast;
          end
        end
        ST_ISSUE: begin
          wd        <= '0;
          first_blk <= 1'b0;
        end
        ST_WAIT: begin
          wd <= wd + WD_W'(1);
          if (!iAbort) begin
            if (timeout) begin
              error <= ERR_TIMEOUT;
            end else if (iCoreDone) begin
              if (blk_cnt != '1) blk_cnt <= blk_cnt + CNT_W'(1);
              if (last_blk) begin
                hash       <= iCoreHash;
                hash_valid <= 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (iHashAck) begin
            hash_valid <= 1'b0;
            first_blk  <= 1'b1;
            last_blk   <= 1'b0;
            blk_cnt    <= '0;
          end
        end
        ST_ABORT: begin
          wd         <= '0;
          first_blk  <= 1'b1;
          last_blk   <= 1'b0;
          hash_valid <= 1'b0;
          blk_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign oHash       = hash;
  assign oHashValid  = hash_valid;
  assign oError      = error;
  assign oBlockCount = blk_cnt;
  assign oCoreBlock  = block;
  assign oBusy       = ((state != ST_IDLE) && (state != ST_HOLD)) || iCoreBusy;

endmodule
